// File: rtl/servo_pkg.sv
// -----------------------------------------------------------------------------
// servo_pkg
// Shared definitions for the servo PWM bank.
//   - Default parameter values (position width, frame length, pulse offset,
//     step multiplier/shift, slew step).
//   - pos_t:        servo position type at the default width.
//   - pos_to_width: position -> pulse width in clocks, clamped to PERIOD-1.
// Optional feature macro used by the bank: SERVO_SLEW_EN (see servo_pwm_chan).
// -----------------------------------------------------------------------------
package servo_pkg;

  localparam int DEF_POS_W     = 8;
  localparam int DEF_PERIOD    = 900_000;
  localparam int DEF_OFFSET    = 50_000;
  localparam int DEF_SDM       = 3125;
  localparam int DEF_SDD_SHIFT = 4;
  localparam int DEF_SLEW_STEP = 4;

  typedef logic [DEF_POS_W-1:0] pos_t;

  // The product is formed in 64 bits, which covers POS_W + $clog2(SDM+1)
  // for any sane parameter set, so nothing is lost before the shift.
  // Clamping to PERIOD-1 guarantees at least one low cycle per frame.
  function automatic logic [31:0] pos_to_width(
    input logic [31:0] pos,
    input int          offset,
    input int          sdm,
    input int          sdd_shift,
    input int          period
  );
    logic [63:0] prod;
    logic [63:0] wid;
    prod = 64'(pos) * 64'(sdm);
    wid  = 64'(offset) + (prod >> sdd_shift);
    if (wid > 64'(period - 1)) begin
      wid = 64'(period - 1);
    end
    return wid[31:0];
  endfunction

endpackage

// File: rtl/servo_pwm_chan.sv
// -----------------------------------------------------------------------------
// servo_pwm_chan
// One servo channel: shadow/active position registers, optional slew limit,
// pulse width calculation and the registered compare against the frame count.
// Optional feature macro: SERVO_SLEW_EN (limit active position movement to
// SLEW_STEP per frame; otherwise active jumps straight to the target).
// Ports:
//   clock_i    clock
//   reset      synchronous active-high reset
//   i_wr       write strobe already decoded for this channel
//   i_wr_pos   position being written
//   i_boundary high on the last cycle of the frame (commit point)
//   i_en       channel enable, latched at the boundary
//   i_count    shared frame counter
//   o_pwm      registered pulse output
// -----------------------------------------------------------------------------
module servo_pwm_chan
  import servo_pkg::*;
#(
  parameter int POS_W     = DEF_POS_W,
  parameter int PERIOD    = DEF_PERIOD,
  parameter int OFFSET    = DEF_OFFSET,
  parameter int SDM       = DEF_SDM,
  parameter int SDD_SHIFT = DEF_SDD_SHIFT,
  parameter int SLEW_STEP = DEF_SLEW_STEP,
  parameter int CNT_W     = $clog2(DEF_PERIOD)
) (
  input  logic             clock_i,
  input  logic             reset,
  input  logic             i_wr,
  input  logic [POS_W-1:0] i_wr_pos,
  input  logic             i_boundary,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_count,
  output logic             o_pwm
);

  // Without slewing the step is wider than any possible distance, so the
  // limiter below always lands directly on the target and folds away.
`ifdef SERVO_SLEW_EN
  localparam int EFF_STEP = SLEW_STEP;
`else
  localparam int EFF_STEP = 1 << POS_W;
`endif
  localparam logic [POS_W:0] STEP = (POS_W + 1)'(EFF_STEP);

  logic [POS_W-1:0] r_shadow;
  logic [POS_W-1:0] r_active;
  logic             r_en;
  logic             r_pwm;
  logic [POS_W-1:0] w_target;
  logic [POS_W-1:0] w_next_active;
  logic [POS_W:0]   w_up;
  logic [POS_W:0]   w_dn;
  logic [CNT_W-1:0] w_width;

  always_comb begin
    // A write in the boundary cycle is forwarded straight into the commit.
    w_target      = i_wr ? i_wr_pos : r_shadow;
    w_up          = {1'b0, w_target} - {1'b0, r_active};
    w_dn          = {1'b0, r_active} - {1'b0, w_target};
    w_next_active = w_target;
    if ((w_target > r_active) && (w_up > STEP)) begin
      w_next_active = r_active + STEP[POS_W-1:0];
    end else if ((w_target < r_active) && (w_dn > STEP)) begin
      w_next_active = r_active - STEP[POS_W-1:0];
    end
  end

  assign w_width = CNT_W'(pos_to_width(32'(r_active), OFFSET, SDM, SDD_SHIFT, PERIOD));

  always_ff @(posedge clock_i) begin
    if (reset) begin
      r_shadow <= '0;
      r_active <= '0;
      r_en     <= 1'b0;
      r_pwm    <= 1'b0;
    end else begin
      if (i_wr) begin
        r_shadow <= i_wr_pos;
      end
      if (i_boundary) begin
        r_active <= w_next_active;
        r_en     <= i_en;
      end
      r_pwm <= r_en && (i_count < w_width);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/servo_pwm_bank.sv
// -----------------------------------------------------------------------------
// servo_pwm_bank
// NUM_CH servo PWM outputs sharing one frame counter. Positions are written
// into per-channel shadow registers at any time and committed at the frame
// boundary, so a pulse is never altered mid-frame.
// Optional feature macro: SERVO_SLEW_EN (per-frame slew limit, SLEW_STEP).
// Ports:
//   clock_i    clock
//   reset      synchronous active-high reset
//   wr_en_i    position write strobe
//   wr_chan_i  target channel (writes to channels >= NUM_CH are dropped)
//   wr_pos_i   new target position
//   en_i       per-channel enables, sampled at the frame boundary
//   pwm_o      registered servo pulses
//   frame_o    one-cycle pulse on the first cycle of each frame
// -----------------------------------------------------------------------------
module servo_pwm_bank
  import servo_pkg::*;
#(
  parameter int NUM_CH    = 8,
  parameter int POS_W     = DEF_POS_W,
  parameter int PERIOD    = DEF_PERIOD,
  parameter int OFFSET    = DEF_OFFSET,
  parameter int SDM       = DEF_SDM,
  parameter int SDD_SHIFT = DEF_SDD_SHIFT,
  parameter int SLEW_STEP = DEF_SLEW_STEP,
  localparam int WA_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W    = $clog2(PERIOD)
) (
  input  logic              clock_i,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [WA_W-1:0]   wr_chan_i,
  input  logic [POS_W-1:0]  wr_pos_i,
  input  logic [NUM_CH-1:0] en_i,
  output logic [NUM_CH-1:0] pwm_o,
  output logic              frame_o
);

  logic [CNT_W-1:0]  r_count;
  logic              r_frame;
  logic              w_boundary;
  logic [NUM_CH-1:0] w_wr;

  assign w_boundary = (r_count == CNT_W'(PERIOD - 1));

  always_ff @(posedge clock_i) begin
    if (reset) begin
      r_count <= '0;
      r_frame <= 1'b0;
    end else begin
      r_count <= w_boundary ? '0 : r_count + 1'b1;
      // Registered like the pulses, so it lines up with the first high cycle.
      r_frame <= (r_count == '0);
    end
  end

  assign frame_o = r_frame;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      // Out-of-range channel numbers match no instance and are dropped.
      assign w_wr[gi] = wr_en_i && (wr_chan_i == WA_W'(gi));

      servo_pwm_chan #(
        .POS_W     (POS_W),
        .PERIOD    (PERIOD),
        .OFFSET    (OFFSET),
        .SDM       (SDM),
        .SDD_SHIFT (SDD_SHIFT),
        .SLEW_STEP (SLEW_STEP),
        .CNT_W     (CNT_W)
      ) u_chan (
        .clock_i    (clock_i),
        .reset      (reset),
        .i_wr       (w_wr[gi]),
        .i_wr_pos   (wr_pos_i),
        .i_boundary (w_boundary),
        .i_en       (en_i[gi]),
        .i_count    (r_count),
        .o_pwm      (pwm_o[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_servo_pwm_bank.sv
// -----------------------------------------------------------------------------
// tb_servo_pwm_bank
// Directed bench: a 4-channel bank and a 5-channel bank (3-bit address, used
// for out-of-range writes) share clock and reset. Each measured frame counts
// high cycles per channel from the frame_o cycle onward.
// Optional feature macro: SERVO_SLEW_EN selects the slew scenario.
// -----------------------------------------------------------------------------
module tb_servo_pwm_bank;
  import servo_pkg::*;

  localparam int PER = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_ch;
  pos_t       wr_pos;
  logic [3:0] en;
  logic [3:0] pwm;
  logic       frame;
  logic       wr_en5;
  logic [2:0] wr_ch5;
  pos_t       wr_pos5;
  logic [4:0] en5;
  logic [4:0] pwm5;
  logic       frame5;

  int checks = 0;
  int errors = 0;
  int exp4[4];
  int exp5[5];
  int wr_idx, wr_dut, wr_c, wr_p, en_idx;
  logic [3:0] en_val;
  int waited;

  always #5 clk = ~clk;

  servo_pwm_bank #(
    .NUM_CH(4), .POS_W(8), .PERIOD(PER), .OFFSET(10), .SDM(3), .SDD_SHIFT(1), .SLEW_STEP(4)
  ) dut (
    .clock_i(clk), .reset(rst), .wr_en_i(wr_en), .wr_chan_i(wr_ch), .wr_pos_i(wr_pos),
    .en_i(en), .pwm_o(pwm), .frame_o(frame)
  );

  servo_pwm_bank #(
    .NUM_CH(5), .POS_W(8), .PERIOD(PER), .OFFSET(10), .SDM(3), .SDD_SHIFT(1), .SLEW_STEP(4)
  ) dut5 (
    .clock_i(clk), .reset(rst), .wr_en_i(wr_en5), .wr_chan_i(wr_ch5), .wr_pos_i(wr_pos5),
    .en_i(en5), .pwm_o(pwm5), .frame_o(frame5)
  );

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Waits (bounded) for frame_o, then samples one full frame of PER cycles.
  // Sample k sees the compare result for counter value k; a write issued at
  // sample k is captured while the counter is k+1, so k=PER-2 hits the boundary.
  task automatic run_window(input string name, output int n_wait);
    int c4[4];
    int c5[5];
    logic [3:0] first4;
    logic [4:0] first5;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame && n < 2 * PER);
    n_wait = n;
    chk({name, " frame_o seen"}, int'(frame), 1);
    chk({name, " frame_o dut5"}, int'(frame5), 1);
    c4 = '{0, 0, 0, 0};
    c5 = '{0, 0, 0, 0, 0};
    first4 = pwm;
    first5 = pwm5;
    for (int k = 0; k < PER; k++) begin
      if (k > 0) @(negedge clk);
      for (int c = 0; c < 4; c++) c4[c] += int'(pwm[c]);
      for (int c = 0; c < 5; c++) c5[c] += int'(pwm5[c]);
      if (k == wr_idx) begin
        if (wr_dut == 0) begin
          wr_en = 1'b1; wr_ch = wr_c[1:0]; wr_pos = wr_p[7:0];
        end else begin
          wr_en5 = 1'b1; wr_ch5 = wr_c[2:0]; wr_pos5 = wr_p[7:0];
        end
      end else if (k == wr_idx + 1) begin
        wr_en = 1'b0;
        wr_en5 = 1'b0;
      end
      if (k == en_idx) en = en_val;
    end
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("%s ch%0d high cycles", name, c), c4[c], exp4[c]);
      chk($sformatf("%s ch%0d aligned", name, c), int'(first4[c]), int'(exp4[c] > 0));
    end
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("%s dut5 ch%0d high cycles", name, c), c5[c], exp5[c]);
    end
    wr_idx = -1;
    en_idx = -1;
    $display("frame %s: ch0..3 = %0d %0d %0d %0d", name, c4[0], c4[1], c4[2], c4[3]);
  endtask

  initial begin
    int n;
    rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_pos = '0; en = 4'hF;
    wr_en5 = 1'b0; wr_ch5 = '0; wr_pos5 = '0; en5 = 5'h1F;
    wr_idx = -1; wr_dut = 0; wr_c = 0; wr_p = 0; en_idx = -1; en_val = 4'hF;
    repeat (3) @(negedge clk);
    chk("reset pwm_o", int'(pwm), 0);
    chk("reset frame_o", int'(frame), 0);
    chk("reset dut5 pwm_o", int'(pwm5), 0);
    rst = 1'b0;

`ifdef SERVO_SLEW_EN
    exp4 = '{0, 0, 0, 0}; exp5 = '{0, 0, 0, 0, 0};
    wr_idx = 50; wr_dut = 0; wr_c = 0; wr_p = 10;
    run_window("slew0", waited);
    chk("first frame_o after reset", waited, 1);
    exp5 = '{10, 10, 10, 10, 10};
    exp4 = '{16, 10, 10, 10}; run_window("slew1", waited);
    exp4 = '{22, 10, 10, 10}; run_window("slew2", waited);
    exp4 = '{25, 10, 10, 10}; run_window("slew3", waited);
    exp4 = '{25, 10, 10, 10}; run_window("slew4", waited);
`else
    exp4 = '{0, 0, 0, 0}; exp5 = '{0, 0, 0, 0, 0};
    run_window("first", waited);
    chk("first frame_o after reset", waited, 1);
    exp5 = '{10, 10, 10, 10, 10};

    exp4 = '{10, 10, 10, 10};
    wr_idx = 50; wr_dut = 0; wr_c = 2; wr_p = 20;
    run_window("base", waited);

    exp4 = '{10, 10, 40, 10};
    wr_idx = 50; wr_dut = 0; wr_c = 1; wr_p = 200;
    run_window("ch2_20", waited);

    exp4 = '{10, 99, 40, 10};
    wr_idx = PER - 2; wr_dut = 0; wr_c = 0; wr_p = 8;
    run_window("ch1_clamp", waited);

    exp4 = '{22, 99, 40, 10};
    en_idx = 50; en_val = 4'h7;
    run_window("ch0_fwd", waited);

    exp4 = '{22, 99, 40, 0};
    wr_idx = 50; wr_dut = 1; wr_c = 5; wr_p = 200;
    run_window("ch3_off", waited);

    wr_idx = 50; wr_dut = 1; wr_c = 7; wr_p = 200;
    run_window("bad_ch5", waited);

    run_window("bad_ch7", waited);

    // Reset in the middle of the ch0 pulse.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame && n < 2 * PER);
    chk("pre-reset frame_o", int'(frame), 1);
    repeat (5) @(negedge clk);
    chk("pre-reset ch0 high", int'(pwm[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid reset pwm_o", int'(pwm), 0);
    chk("mid reset frame_o", int'(frame), 0);
    chk("mid reset dut5 pwm_o", int'(pwm5), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    exp4 = '{0, 0, 0, 0}; exp5 = '{0, 0, 0, 0, 0};
    run_window("post_rst", waited);
    chk("counter restart", waited, 1);

    exp4 = '{10, 10, 10, 0}; exp5 = '{10, 10, 10, 10, 10};
    run_window("post_rst2", waited);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/servo_pwm_bank.md
Name: servo_pwm_bank

Overview:
Multi-channel successor to the single-servo PWM generator. It drives NUM_CH servo outputs from one shared frame counter. Each channel has a write-anytime shadow position that is committed to the active position only at the frame boundary, so pulses are never glitched mid-frame. It sits behind the SPI register decoder, which issues position writes and channel enables.

Parameters:
NUM_CH, 8, number of servo channels (1..32)
POS_W, 8, position width in bits
PERIOD, 900_000, frame length in clocks; counter runs 0..PERIOD-1
OFFSET, 50_000, pulse width in clocks at position 0
SDM, 3125, step multiplier
SDD_SHIFT, 4, step divisor as right shift (divide by 16)
SLEW_STEP, 4, maximum position change per frame (used only with the optional feature)

Ports:
clock_i  in  1  system clock
reset  in  1  synchronous, active-high reset
wr_en_i  in  1  position write strobe, one write per cycle, always accepted
wr_chan_i  in  $clog2(NUM_CH) (min 1)  target channel for the write
wr_pos_i  in  POS_W  new target position
en_i  in  NUM_CH  per-channel enable, sampled at the frame boundary
pwm_o  out  NUM_CH  registered servo pulse outputs
frame_o  out  1  one-cycle pulse marking the first cycle of each frame

Behaviour:
- Reset clears: counter, all shadow and active positions, latched enables, pwm_o and frame_o (all 0). Reset asserted mid-frame aborts the frame; counter restarts at 0 on the cycle after reset deasserts.
- Counter: increments each cycle and wraps from PERIOD-1 to 0. "Boundary cycle" means counter == PERIOD-1.
- Write: when wr_en_i is high, shadow[wr_chan_i] <= wr_pos_i. If wr_chan_i >= NUM_CH, the write is ignored with no side effects.
- Commit: on the boundary cycle, active[c] <= shadow[c] and en_act <= en_i.
  - A write in the boundary cycle itself is forwarded, so active takes wr_pos_i.
  - Writes on any other cycle affect the next frame only.
- Width: width[c] = OFFSET + ((active[c] * SDM) >> SDD_SHIFT). Compute at full precision: POS_W + $clog2(SDM+1) bits before the shift. Clamp to PERIOD-1, which guarantees at least one low cycle per frame.
- Output: pwm_o[c] <= en_act[c] && (counter < width[c]). This is registered, so there is 1 cycle latency from counter to pin. Each enabled channel is high for exactly width[c] clocks per frame, starting on the cycle frame_o is high.
- frame_o <= (counter == 0). The first frame after reset has all outputs low because en_act = 0.
- Disabled channel: pwm_o stays low for the whole frame. Enabling or disabling takes effect only at a frame boundary.

Optional Feature:
SERVO_SLEW_EN
- Defined: at each boundary, active[c] moves toward shadow[c] by at most SLEW_STEP. If the remaining distance is at most SLEW_STEP, active lands exactly on shadow with no overshoot. Boundary-cycle write forwarding still applies, but to the slew target.
- Undefined: active[c] jumps directly to shadow[c]. SLEW_STEP is unused.

Decomposition:
- Shared package servo_pkg holds:
  - Default constants: PERIOD, OFFSET, SDM, SDD_SHIFT, POS_W.
  - Function pos_to_width(pos), including the clamp.
  - typedef pos_t.
- One sub-module, servo_pwm_chan, per channel. It holds the shadow and active registers, the slew logic, the width calculation and the compare. The top level holds the counter, frame_o, the write decode and the generate loop.

Test Plan:
- Test parameters for all scenarios: PERIOD=100, OFFSET=10, SDM=3, SDD_SHIFT=1, NUM_CH=4.
- Reset, then en_i=4'hF with no writes -> first frame all low; from the second frame every pwm_o is high 10 cycles per frame, aligned with frame_o.
- Write ch2=20 mid-frame -> current frame unchanged; next frame ch2 is high 10+30=40 cycles; other channels stay at 10.
- Write ch1=200 -> width 310 clamps to 99: high 99 cycles, low 1 cycle per frame.
- Write in the boundary cycle, ch0=8 -> the next frame already shows 22 cycles. Write with wr_chan_i=5 on a bench with NUM_CH=5 rounded to a 3-bit address -> no change on any channel.
- Deassert en_i[3] mid-frame -> ch3 finishes the current frame normally and is low from the next frame. Assert reset mid-pulse -> all outputs low on the next cycle and the counter restarts.
- With SERVO_SLEW_EN and SLEW_STEP=4, write ch0 from 0 to 10 -> active goes 4, 8, 10 over three frames; widths 16, 22, 25.
